// File: rtl/tick_delay_arbiter.sv
// tick_delay_arbiter
//
// Shares one down-counting tick timer among M requesters. Pending requests are
// arbitrated round-robin; the winner's delay is loaded into the timer, which
// counts down on the shared tick enable. When the delay expires, the winner
// gets a one-cycle done pulse. Only one requester owns the timer at a time.
//
// Ports:
//   clk    - system clock; all state changes on the rising edge
//   rst    - synchronous, active-high reset
//   ena    - tick enable; the timer only decrements in cycles where ena=1
//   req    - per-requester request level (bit i = requester i)
//   delay  - packed delays; requester i uses bits [i*N +: N]
//   grant  - one-hot owner of the timer (registered)
//   done   - one-hot, one-cycle pulse when the granted delay expires (registered)
//   busy   - high whenever the block is not idle (registered)
//
// All outputs come straight from flops, so there is no combinational path from
// req, delay or ena to any output.

module tick_delay_arbiter #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [M-1:0]   req,
  input  logic [M*N-1:0] delay,
  output logic [M-1:0]   grant,
  output logic [M-1:0]   done,
  output logic           busy
);

  localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1;
  // After reset the pointer sits on the top requester, so requester 0 wins first.
  localparam logic [IdxW-1:0] LastIdxRst = IdxW'(M - 1);
  localparam logic [N-1:0] CountOne = N'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    grant_q, grant_d;
  logic [M-1:0]    done_q, done_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    remaining_q, remaining_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;

  // Unpack the flat delay bus into one entry per requester.
  logic [N-1:0] delay_arr [M];

  for (genvar gi = 0; gi < M; gi++) begin : g_unpack
    assign delay_arr[gi] = delay[gi*N +: N];
  end

  // Round-robin winner: first set req bit searching upward from last_q+1,
  // wrapping modulo M. The last-served requester is checked last.
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;
  logic [M-1:0]    win_oh;
  logic [N-1:0]    win_delay;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= M; k++) begin
      cand = IdxW'((32'(last_q) + k) % M);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    win_delay       = delay_arr[win_idx];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    remaining_d = remaining_q;
    owner_d     = owner_q;
    last_d      = last_q;

    case (state_q)
      StIdle: begin
        grant_d = '0;
        if (win_valid) begin
          grant_d     = win_oh;
          owner_d     = win_idx;
          remaining_d = win_delay;
          if (win_delay == '0) begin
            // Zero delay expires immediately: grant and done in the same cycle.
            state_d = StDone;
            done_d  = win_oh;
          end else begin
            state_d = StCount;
          end
        end
      end

      StCount: begin
        if (!req[owner_q]) begin
          // Cancel wins over expiry; no done pulse, owner moves to lowest priority.
          state_d = StIdle;
          grant_d = '0;
          last_d  = owner_q;
        end else if (ena) begin
          if (remaining_q == CountOne) begin
            state_d     = StDone;
            remaining_d = '0;
            done_d      = grant_q;
          end else begin
            remaining_d = remaining_q - CountOne;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        grant_d = '0;
        last_d  = owner_q;
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
      owner_q     <= '0;
      last_q      <= LastIdxRst;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      remaining_q <= remaining_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: doc/tick_delay_arbiter.md
Name: tick_delay_arbiter

Overview:
Shares one down-counting tick timer among M requesters, each asking for a delay of D enable-ticks. The block round-robin arbitrates requests, loads the winner's delay and counts on the shared tick enable (normally driven by the pulse generator output). It returns a one-cycle done pulse to the winner. It sits between the pulse generator and client FSMs that need timed waits, replacing per-client counters.

Parameters:
N, 8, width of each delay value and of the internal remaining-count register
M, 4, number of requesters (M >= 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  tick enable; the timer decrements only in cycles where ena=1
req  input  M  per-requester request level; bit i = requester i
delay  input  M*N  packed delays; requester i uses bits [i*N +: N]
grant  output  M  one-hot; the requester currently owning the timer
done  output  M  one-hot, one-cycle pulse; the granted delay has expired
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state=IDLE, grant=0, done=0, busy=0, remaining=0, last_grant pointer=M-1, so requester 0 has priority first. Reset overrides everything, including mid-count; no done is emitted.
- All outputs are registered. There is no combinational path from req, delay or ena to any output.
- States:
  - IDLE → COUNT, or IDLE → DONE when delay=0.
  - COUNT → DONE, or COUNT → IDLE on cancel.
  - DONE → IDLE.
- IDLE:
  - If req != 0, select the winner w: the first set bit searching upward from last_grant+1, wrapping modulo M.
  - Next cycle: grant = one-hot(w) and remaining = delay[w], sampled only at this edge.
  - If delay[w] != 0, go to COUNT; if delay[w] = 0, go directly to DONE.
  - If req = 0, stay in IDLE with all outputs 0.
- COUNT:
  - grant is held and busy=1.
  - If req[w]=0: cancel. Go to IDLE next cycle; grant clears, no done pulse, last_grant=w.
  - Otherwise, if ena=1 and remaining=1: go to DONE and set remaining=0.
  - Otherwise, if ena=1: remaining decrements by 1.
  - Otherwise (ena=0): hold.
  - Cancel takes priority over expiry in the same cycle.
- DONE:
  - done = one-hot(w) for exactly this one cycle; grant is still asserted this cycle.
  - Next cycle: IDLE, grant=0, done=0, last_grant=w.
  - ena and req are ignored in DONE.
- Latency: req seen in IDLE at cycle t gives grant at t+1. With ena held high, done is at t+1+D; D=0 gives done at t+1. With ena gated, done follows the D-th ena-high cycle counted from t+1 inclusive, by one cycle.
- A new arbitration happens only in IDLE, so there is one idle cycle between consecutive grants.
- A requester holding req after done re-enters arbitration at lowest priority relative to the others (round-robin fairness).
- Changes to delay[w] while granted have no effect. Changes to other requesters' delays are irrelevant until they win.
- The remaining counter is N bits wide and never wraps: it loads at most 2^N-1 and stops at 1→DONE.
- done is never asserted without the matching grant bit being high in the same cycle.
- grant and done are always zero or one-hot.

Test Plan:
- Single request: req=4'b0001, delay[0]=3, ena=1 continuously, req asserted at cycle 0 → grant=0001 cycles 1–4, busy=1 cycles 1–4, done=0001 at cycle 4 only, grant=0 at cycle 5.
- Zero delay: req=4'b0100, delay[2]=0 → grant=0100 and done=0100 both at cycle 1 only; busy=0 at cycle 2.
- Round-robin contention: req=4'b1111, all delays=2, ena=1, req held after done → grant order 0,1,2,3,0; done cycles 3,7,11,15; exactly one idle cycle between grants.
- Enable gating: req=4'b0010, delay[1]=3, ena high only every 4th cycle starting cycle 1 (cycles 1,5,9) → done=0010 at cycle 10; remaining holds between ticks.
- Cancel: req=4'b1000, delay[3]=10, ena=1, req[3] dropped at cycle 4 → no done ever; grant=0 and busy=0 from cycle 5; a subsequent req=4'b1001 grants requester 0 first.
- Reset mid-operation: rst=1 at cycle 3 during COUNT with delay=5 → cycle 4: grant=0, done=0, busy=0. After release, req=4'b1111 grants requester 0 first.
